// File: rtl/mem_bist.sv
// mem_bist: multi-pattern write-then-verify sweep engine for the PSRAM controller
module mem_bist #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int ERR_W = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        pattern_mask,
  input  logic              continuous,
  input  logic              mem_initialized,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ERR_W-1:0]  errors,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       pass_count,
  output logic [1:0]        cur_pattern
);
  localparam int LW = $clog2(DATA_W);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_INIT = 3'd1, S_SELECT = 3'd2, S_WRITE = 3'd3,
                         S_GAP = 3'd4, S_READ = 3'd5, S_NEXT = 3'd6, S_DONE = 3'd7;
  logic [2:0] state, idx, nidx;
  logic [3:0] mask_q;
  logic cont_q, stop_pend, sel_found, more, last, mismatch;
  logic [1:0] sel_idx;
  logic [DATA_W-1:0] a_ext, one_hot;
  always_comb begin
    sel_found = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (mask_q[i] && 3'(i) >= idx) begin
        sel_found = 1'b1;
        sel_idx = 2'(i);
      end
  end
  // idx is one past the pattern just run; 4 means no patterns remain
  assign nidx = {1'b0, cur_pattern} + 3'd1;
  assign more = |(mask_q & ~((4'd1 << nidx) - 4'd1));
  assign a_ext = DATA_W'(mem_addr);
  assign one_hot = {{(DATA_W-1){1'b0}}, 1'b1} << a_ext[LW-1:0];
  assign mem_wdata = cur_pattern == 2'd0 ? a_ext :
                     cur_pattern == 2'd1 ? ~a_ext :
                     cur_pattern == 2'd2 ? (mem_addr[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}}) :
                     one_hot;
  assign last = mem_addr == LAST_ADDR;
  assign mismatch = mem_rdata != mem_wdata;
  assign mem = state == S_WRITE || state == S_READ;
  assign rw = state == S_READ;
  assign busy = state != S_IDLE && state != S_DONE;
  assign done = state == S_DONE;
  assign fail = done && errors != '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx <= '0;
      mask_q <= '0;
      cont_q <= 1'b0;
      stop_pend <= 1'b0;
      mem_addr <= '0;
      errors <= '0;
      first_err_valid <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass_count <= '0;
      cur_pattern <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          errors <= '0;
          first_err_valid <= 1'b0;
          first_err_addr <= '0;
          first_err_data <= '0;
          pass_count <= '0;
          mask_q <= pattern_mask;
          cont_q <= continuous;
          idx <= '0;
          stop_pend <= 1'b0;
          state <= S_WAIT_INIT;
        end
        S_WAIT_INIT: state <= stop ? S_DONE : mem_initialized ? S_SELECT : S_WAIT_INIT;
        S_SELECT: begin
          cur_pattern <= sel_found ? sel_idx : cur_pattern;
          mem_addr <= '0;
          state <= (stop || !sel_found) ? S_DONE : S_WRITE;
        end
        S_WRITE, S_READ: begin
          if (stop) stop_pend <= 1'b1;
          if (mem_ready) begin
            mem_addr <= last ? '0 : mem_addr + ADDR_W'(1);
            if (state == S_READ && mismatch) begin
              errors <= errors == '1 ? errors : errors + ERR_W'(1);
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr <= mem_addr;
                first_err_data <= mem_rdata;
              end
            end
            state <= (stop || stop_pend) ? S_DONE : !last ? state : state == S_WRITE ? S_GAP : S_NEXT;
          end
        end
        S_GAP: state <= stop ? S_DONE : S_READ;
        S_NEXT: begin
          if (stop) state <= S_DONE;
          else if (more) begin
            idx <= nidx;
            state <= S_SELECT;
          end else begin
            pass_count <= pass_count + 16'd1;
            idx <= '0;
            state <= (cont_q && !stop_pend) ? S_SELECT : S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
